// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data memory serving MEM-stage loads/stores.
// Optional build macro DMEM_BYTE_WRITE_EN honours ByteEnM per lane; otherwise stores write all 32 bits.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValidM,
  input  logic        ReqWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic        ReqReadyM,
  output logic        RespValidM,
  output logic [31:0] ReadDataM,
  output logic        MisalignErr,
  output logic        StallM
);
  localparam int         DATA_W   = 32;
  localparam int         AW       = DEPTH_LOG2;
  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [AW-1:0]       idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic                mis_q;
  logic [3:0]          be_q;

  logic [DATA_W-1:0]   mem_q [WORDS];

  logic                accept;
  logic                commit;
  logic [3:0]          be_in;
  logic [AW-1:0]       c_idx;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_we;
  logic                c_mis;
  logic [3:0]          c_be;

`ifdef DMEM_BYTE_WRITE_EN
  assign be_in = ByteEnM;
  logic unused_addr_hi;
  assign unused_addr_hi = ^AddrM[31:AW+2];
`else
  assign be_in = 4'hF;
  logic unused_inputs;
  assign unused_inputs = ^{AddrM[31:AW+2], ByteEnM};
`endif

  assign ReqReadyM   = (state_q != S_WAIT);
  assign StallM      = (state_q == S_WAIT);
  assign RespValidM  = (state_q == S_RESP);
  assign MisalignErr = err_q;
  assign ReadDataM   = rdata_q;
  assign accept      = ReqValidM && ReqReadyM;

  // With LATENCY==1 the commit edge is the accept edge, so the live inputs are used directly.
  assign c_idx   = DIRECT ? AddrM[AW+1:2]        : idx_q;
  assign c_wdata = DIRECT ? WriteDataM           : wdata_q;
  assign c_we    = DIRECT ? ReqWriteM            : we_q;
  assign c_mis   = DIRECT ? (AddrM[1:0] != 2'b00) : mis_q;
  assign c_be    = DIRECT ? be_in                : be_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          if (DIRECT) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (commit) begin
      err_d = c_mis;
      if (!c_we) rdata_d = c_mis ? '0 : mem_q[c_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture: data-only registers, loaded on the accept edge.
  always_ff @(posedge CLK) begin
    if (accept) begin
      idx_q   <= AddrM[AW+1:2];
      wdata_q <= WriteDataM;
      we_q    <= ReqWriteM;
      be_q    <= be_in;
      mis_q   <= (AddrM[1:0] != 2'b00);
    end
  end

  // A reset on the commit edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && commit && c_we && !c_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

endmodule
